// File: rtl/multicycle_ctrl.sv
// Multicycle RV32 control FSM: fetch/decode/execute/memory/writeback/trap.
// Define CTRL_PERF_CNT_EN to build the cycle and instret counters.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        mem_ready,
  input  logic        branch_taken,
  output logic [2:0]  state,
  output logic        ir_write,
  output logic        mem_read,
  output logic        mem_write,
  output logic        reg_write,
  output logic        pc_write,
  output logic        pc_sel,
  output logic        trap,
  output logic [31:0] instret_cnt,
  output logic [31:0] cycle_cnt
);

  typedef enum logic [2:0] {
    FETCH     = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4,
    TRAP      = 3'd5
  } state_e;

  typedef enum logic [2:0] {
    C_ALU, C_LOAD, C_STORE, C_BRANCH,
    C_JUMP, C_FENCE, C_ILL
  } cls_e;

  state_e st_q, st_d;
  cls_e   cls_q, dec_cls;
  logic   ir_w, mr, mw, rw, pw, ps, tr;

  always_comb begin
    dec_cls = C_ILL;
    unique case (1'b1)
      (opcode == 7'b0110011) ||
      (opcode == 7'b0010011) ||
      (opcode == 7'b0110111) ||
      (opcode == 7'b0010111): dec_cls = C_ALU;
      (opcode == 7'b0000011): dec_cls = C_LOAD;
      (opcode == 7'b0100011): dec_cls = C_STORE;
      (opcode == 7'b1100011): dec_cls = C_BRANCH;
      (opcode == 7'b1101111) ||
      (opcode == 7'b1100111): dec_cls = C_JUMP;
      (opcode == 7'b0001111): dec_cls = C_FENCE;
      default:                dec_cls = C_ILL;
    endcase
  end

  always_comb begin
    st_d = st_q;
    ir_w = 1'b0;
    mr   = 1'b0;
    mw   = 1'b0;
    rw   = 1'b0;
    pw   = 1'b0;
    ps   = 1'b0;
    tr   = 1'b0;
    case (st_q)
      FETCH: begin
        mr = 1'b1;
        if (mem_ready) begin
          ir_w = 1'b1;
          st_d = DECODE;
        end
      end
      DECODE: begin
        case (dec_cls)
          C_FENCE: begin
            pw   = 1'b1;
            st_d = FETCH;
          end
          C_ILL:   st_d = TRAP;
          default: st_d = EXECUTE;
        endcase
      end
      EXECUTE: begin
        case (cls_q)
          C_ALU, C_JUMP:   st_d = WRITEBACK;
          C_LOAD, C_STORE: st_d = MEMORY;
          C_BRANCH: begin
            pw   = 1'b1;
            ps   = branch_taken;
            st_d = FETCH;
          end
          default: st_d = TRAP;
        endcase
      end
      MEMORY: begin
        mr = (cls_q == C_LOAD);
        mw = (cls_q == C_STORE);
        if (!mr && !mw) begin
          st_d = TRAP;
        end else if (mem_ready) begin
          if (mr) begin
            st_d = WRITEBACK;
          end else begin
            pw   = 1'b1;
            st_d = FETCH;
          end
        end
      end
      WRITEBACK: begin
        rw   = 1'b1;
        pw   = 1'b1;
        ps   = (cls_q == C_JUMP);
        st_d = FETCH;
      end
      TRAP:    tr = 1'b1;
      default: st_d = TRAP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      st_q  <= FETCH;
      cls_q <= C_FENCE;
    end else begin
      st_q <= st_d;
      if (st_q == DECODE) cls_q <= dec_cls;
    end
  end

  // strobes are forced low while reset is held, even mid-instruction
  assign state     = st_q;
  assign ir_write  = rst & ir_w;
  assign mem_read  = rst & mr;
  assign mem_write = rst & mw;
  assign reg_write = rst & rw;
  assign pc_write  = rst & pw;
  assign pc_sel    = rst & ps;
  assign trap      = rst & tr;

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_q, ret_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      cyc_q <= '0;
      ret_q <= '0;
    end else begin
      cyc_q <= cyc_q + 32'd1;
      if (pw) ret_q <= ret_q + 32'd1;
    end
  end

  assign cycle_cnt   = rst ? cyc_q : '0;
  assign instret_cnt = rst ? ret_q : '0;
`else
  assign cycle_cnt   = '0;
  assign instret_cnt = '0;
`endif

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 The block SHALL provide `clk` as a 1-bit input, the rising-edge clock.
REQ-003 The block SHALL provide `rst` as a 1-bit input, the synchronous active-low reset (0 = reset).
REQ-004 The block SHALL provide `opcode` as a 7-bit input, instr[6:0] from the instruction register, valid from DECODE onward.
REQ-005 The block SHALL provide `mem_ready` as a 1-bit input, the memory access-complete handshake.
REQ-006 The block SHALL provide `branch_taken` as a 1-bit input, the ALU branch-condition result, valid in EXECUTE.
REQ-007 The block SHALL provide `state` as a 3-bit output, the current FSM state code.
REQ-008 The block SHALL provide `ir_write`, `mem_read`, `mem_write`, `reg_write`, `pc_write`, `pc_sel` and `trap` as 1-bit outputs, the datapath strobes.
REQ-009 The block SHALL provide `instret_cnt` and `cycle_cnt` as 32-bit outputs, the performance counters.

Function
REQ-010 The FSM SHALL use the state codes FETCH=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4 and TRAP=5; codes 6 and 7 SHALL go to TRAP on the next edge.
REQ-011 In FETCH, `mem_read` SHALL be 1; the FSM SHALL hold while `mem_ready`=0; when `mem_ready`=1, `ir_write` SHALL pulse for that cycle and the FSM SHALL go to DECODE.
REQ-012 In DECODE, the opcode class SHALL be latched internally; later states SHALL use only the latched class.
REQ-013 Class map by opcode: ALU = 0110011, 0010011, 0110111 or 0010111; LOAD = 0000011; STORE = 0100011; BRANCH = 1100011; JUMP = 1101111 or 1100111; FENCE = 0001111; anything else, including 1110011, is ILLEGAL.
REQ-014 From DECODE, FENCE SHALL complete (go to FETCH), ILLEGAL SHALL go to TRAP, and every other class SHALL go to EXECUTE.
REQ-015 From EXECUTE, ALU and JUMP SHALL go to WRITEBACK, LOAD and STORE SHALL go to MEMORY, and BRANCH SHALL complete.
REQ-016 In MEMORY, `mem_read` (LOAD) or `mem_write` (STORE) SHALL be 1 and the FSM SHALL hold while `mem_ready`=0.
REQ-017 When `mem_ready`=1 in MEMORY, LOAD SHALL go to WRITEBACK and STORE SHALL complete.
REQ-018 In WRITEBACK, `reg_write` SHALL be 1 for exactly one cycle, after which the instruction SHALL complete.
REQ-019 "Complete" SHALL mean that `pc_write`=1 for exactly one cycle and the next state is FETCH.
REQ-020 On completion, `pc_sel` SHALL be 1 for JUMP, 1 for BRANCH when `branch_taken`=1 in EXECUTE, and 0 otherwise (PC+4).
REQ-021 Outside a completion cycle, `pc_sel` SHALL be 0.
REQ-022 Cycle counts for zero-wait memory SHALL be: ALU/JUMP = 4, LOAD = 5, STORE = 4, BRANCH = 3, FENCE = 2; each `mem_ready`=0 cycle SHALL add one.
REQ-023 TRAP SHALL be sticky until reset; in TRAP, `trap`=1 and all other strobes SHALL be 0.
REQ-024 At most one of `mem_read` and `mem_write` SHALL be 1 in any cycle; `pc_write` and `ir_write` SHALL never both be 1.
REQ-025 `mem_ready` SHALL be ignored in DECODE, EXECUTE, WRITEBACK and TRAP.

Reset
REQ-026 When `rst`=0 at a rising edge, the next state SHALL be FETCH.
REQ-027 During reset, the latched class SHALL be cleared to FENCE.
REQ-028 During reset, all strobes and `trap` SHALL be 0, and `instret_cnt` and `cycle_cnt` SHALL be 0.
REQ-029 Reset SHALL abort any in-progress instruction with no `pc_write`.
REQ-030 In the first cycle after `rst` returns to 1, the FSM SHALL be in FETCH with `mem_read`=1.

Configuration
REQ-031 When CTRL_PERF_CNT_EN is defined, `cycle_cnt` SHALL increment every non-reset cycle, including TRAP.
REQ-032 When CTRL_PERF_CNT_EN is defined, `instret_cnt` SHALL increment on each `pc_write`.
REQ-033 Both counters SHALL wrap from 0xFFFFFFFF to 0.
REQ-034 When CTRL_PERF_CNT_EN is undefined, both outputs SHALL be constant 0 and no counter flops SHALL be inferred.

Verification
REQ-035 The bench SHALL cover: opcode 0110011, `mem_ready` held 1 -> states 0,1,2,4,0; `reg_write` in cycle 4; `pc_write`=1 with `pc_sel`=0 in cycle 4.
REQ-036 The bench SHALL cover: LOAD with `mem_ready`=0 for 2 cycles in MEMORY -> the instruction takes 7 cycles; `mem_read`=1 throughout MEMORY; `reg_write` in the last cycle.
REQ-037 The bench SHALL cover: BRANCH with `branch_taken`=1 -> `pc_write`=1 and `pc_sel`=1 in cycle 3; with `branch_taken`=0 -> `pc_sel`=0.
REQ-038 The bench SHALL cover: opcode 1110011 -> TRAP entered after DECODE; `trap` stays 1 for 20 cycles; then `rst`=0 for 1 cycle -> FETCH with `trap`=0.
REQ-039 The bench SHALL cover: `rst`=0 asserted in MEMORY of a STORE -> no `pc_write`; the next state is FETCH; the counters read 0.
REQ-040 The bench SHALL cover, with CTRL_PERF_CNT_EN defined: `cycle_cnt` forced to 0xFFFFFFFE, two cycles elapse -> reads 0x00000000; 10 FENCE instructions -> `instret_cnt`=10.
